// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants, word type and sizing helpers for the FIFO read stream
package fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;

    typedef logic [DEFAULT_DATA_WIDTH-1:0] data_t;

    // Pointer width for a circular buffer of the given depth (at least one bit)
    function automatic int ptr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    // Occupancy counter width: must hold 0..depth inclusive
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// rtl/fifo_rd_stream_if.sv - FIFO pop port plus valid/ready output stream bundle
interface fifo_rd_stream_if #(
    parameter int DATA_WIDTH = fifo_pkg::DEFAULT_DATA_WIDTH
);
    // FIFO read port
    logic                  r_en;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  empty;

    // Downstream stream
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;

    // master: the reader that pops the FIFO and sources the stream
    modport master (
        output r_en,
        input  r_data,
        input  empty,
        output m_valid,
        input  m_ready,
        output m_data
    );

    // slave: the FIFO plus the downstream sink
    modport slave (
        input  r_en,
        output r_data,
        output empty,
        input  m_valid,
        output m_ready,
        input  m_data
    );
endinterface

// File: rtl/fifo_rd_skid_buf.sv
// rtl/fifo_rd_skid_buf.sv - circular output buffer with push/pop and occupancy count
module fifo_rd_skid_buf
    import fifo_pkg::*;
#(
    parameter int  DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int  BUF_DEPTH  = 2,
    localparam int PTR_W      = ptr_width(BUF_DEPTH),
    localparam int CNT_W      = count_width(BUF_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [CNT_W-1:0]      count,
    output logic [DATA_WIDTH-1:0] head_data
);

    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;

    // Advance a pointer, wrapping at the last entry (depth need not be a power of two)
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Storage is cleared on reset so the head reads as zero before the first word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy update; simultaneous push and pop leaves count unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - FIFO read-side consumer re-presenting data as a valid/ready stream; optional FIFO_RD_STREAM_STATS_EN adds transfer/stall counters
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int BUF_DEPTH  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    fifo_rd_stream_if.master        bus,
    output logic                    busy
`ifdef FIFO_RD_STREAM_STATS_EN
    ,
    output logic [31:0]             xfer_cnt,
    output logic [31:0]             stall_cnt
`endif
);

    localparam int CNT_W = count_width(BUF_DEPTH);

    logic             inflight;
    logic             pop;
    logic [CNT_W-1:0] count;
    logic [CNT_W:0]   credit;

    assign pop = bus.m_valid && bus.m_ready;

    // Slots committed after this edge: buffered words plus the word in flight, minus the one leaving
    assign credit = {1'b0, count} + (CNT_W+1)'(inflight) - (CNT_W+1)'(pop);

    // Issue a read only when a slot is guaranteed for the returning word; held low during reset
    assign bus.r_en = rst_n && en && !bus.empty && (credit < (CNT_W+1)'(BUF_DEPTH));

    assign bus.m_valid = (count != '0);
    assign busy        = (count != '0) || inflight;

    // Remember that a read was issued so its data is captured on the next edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= 1'b0;
        end else begin
            inflight <= bus.r_en;
        end
    end

    fifo_rd_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUF_DEPTH  (BUF_DEPTH)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight),
        .push_data (bus.r_data),
        .pop       (pop),
        .count     (count),
        .head_data (bus.m_data)
    );

`ifdef FIFO_RD_STREAM_STATS_EN
    // Accepted words and back-pressured cycles, both free-running modulo 2^32
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (pop) begin
                xfer_cnt <= xfer_cnt + 32'd1;
            end
            if (bus.m_valid && !bus.m_ready) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb/tb_fifo_rd_stream.sv - self-checking bench for fifo_rd_stream with FIFO model and scoreboard
module tb_fifo_rd_stream;
    import fifo_pkg::*;

    localparam int DW = 32;
    localparam int BD = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic en    = 1'b0;
    logic busy;
`ifdef FIFO_RD_STREAM_STATS_EN
    logic [31:0] xfer_cnt;
    logic [31:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    fifo_rd_stream_if #(.DATA_WIDTH(DW)) bus ();

    fifo_rd_stream #(
        .DATA_WIDTH (DW),
        .BUF_DEPTH  (BD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .bus       (bus),
        .busy      (busy)
`ifdef FIFO_RD_STREAM_STATS_EN
        ,
        .xfer_cnt  (xfer_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    typedef struct {
        int    nwords;
        data_t base;
        int    stall;
        int    exp_stall_ren;
        int    exp_lat;
        int    exp_valid;
    } scen_t;

    scen_t tbl [4];

    data_t fifo_q[$];
    data_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int cyc, ren_cnt, pop_cnt, valid_cyc;
    int first_ren, last_ren, first_pop, last_pop;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_stats();
        cyc = 0; ren_cnt = 0; pop_cnt = 0; valid_cyc = 0;
        first_ren = -1; last_ren = -1; first_pop = -1; last_pop = -1;
    endtask

    task automatic push_word(input data_t d);
        fifo_q.push_back(d);
        exp_q.push_back(d);
        bus.empty = 1'b0;
    endtask

    // One clock: sample pre-edge values, score the stream, then model the FIFO read latency
    task automatic tick();
        logic  ren_s, emp_s, v_s, rdy_s;
        data_t d_s;
        data_t e;
        #2;
        ren_s = bus.r_en; emp_s = bus.empty;
        v_s = bus.m_valid; rdy_s = bus.m_ready; d_s = bus.m_data;
        if (ren_s && emp_s) begin
            checks++; errors++;
            $display("FAIL ren_while_empty actual=1 expected=0 t=%0t", $time);
        end
        if (dut.inflight && int'(dut.u_buf.count) == BD && !(v_s && rdy_s)) begin
            checks++; errors++;
            $display("FAIL overflow actual=capture_into_full expected=no_capture t=%0t", $time);
        end
        if (ren_s) begin
            if (first_ren < 0) first_ren = cyc;
            last_ren = cyc;
            ren_cnt++;
        end
        if (v_s) valid_cyc++;
        if (v_s && rdy_s) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL spurious_word actual=%h expected=none", d_s);
            end else begin
                e = exp_q.pop_front();
                check("stream_data", d_s, e);
            end
            pop_cnt++;
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (ren_s && fifo_q.size() != 0) bus.r_data = fifo_q.pop_front();
        bus.empty = (fifo_q.size() == 0);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || fifo_q.size() != 0 || busy) && n < 300) begin
            tick();
            n++;
        end
        check("drain_left", exp_q.size(), 0);
        check("drain_busy", 32'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int r;
`ifdef FIFO_RD_STREAM_STATS_EN
        logic [31:0] x0, s0;
`endif
        tbl[0] = '{16, 32'h10, 0,  -1, 2,  16};
        tbl[1] = '{8,  32'h10, 10, 2,  -1, -1};
        tbl[2] = '{1,  32'hA5, 0,  -1, 2,  1};
        tbl[3] = '{5,  32'h40, 4,  2,  -1, -1};

        bus.r_data = '0; bus.empty = 1'b0; bus.m_ready = 1'b1;
        en = 1'b1; rst_n = 1'b0;
        clear_stats();

        // Reset held with the FIFO reporting data
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("rst_r_en", 32'(bus.r_en), 0);
            check("rst_m_valid", 32'(bus.m_valid), 0);
            check("rst_m_data", bus.m_data, 0);
            check("rst_busy", 32'(busy), 0);
        end
        bus.empty = 1'b1;
        rst_n = 1'b1;
        tick();

        // Table-driven streaming / back-pressure / single-word scenarios
        for (int s = 0; s < 4; s++) begin
            clear_stats();
            bus.m_ready = (tbl[s].stall == 0);
`ifdef FIFO_RD_STREAM_STATS_EN
            x0 = xfer_cnt; s0 = stall_cnt;
`endif
            for (int k = 0; k < tbl[s].nwords; k++) push_word(tbl[s].base + data_t'(k));
            for (int i = 0; i < tbl[s].stall; i++) begin
                if (i >= 2) begin
                    #2;
                    check("stall_valid", 32'(bus.m_valid), 1);
                    check("stall_head", bus.m_data, tbl[s].base);
                end
                tick();
            end
            if (tbl[s].stall > 0) check("stall_ren", ren_cnt, tbl[s].exp_stall_ren);
            bus.m_ready = 1'b1;
            drain();
            check("ren_total", ren_cnt, tbl[s].nwords);
            check("pop_total", pop_cnt, tbl[s].nwords);
            check("no_gap", last_pop - first_pop + 1, tbl[s].nwords);
            if (tbl[s].exp_lat >= 0) check("latency", first_pop - first_ren, tbl[s].exp_lat);
            if (tbl[s].stall == 0) check("ren_run", last_ren - first_ren + 1, tbl[s].nwords);
            if (tbl[s].exp_valid >= 0) check("valid_cycles", valid_cyc, tbl[s].exp_valid);
`ifdef FIFO_RD_STREAM_STATS_EN
            check("xfer_delta", xfer_cnt - x0, tbl[s].nwords);
            if (tbl[s].stall >= 2) check("stall_delta", stall_cnt - s0, tbl[s].stall - 2);
`endif
            r = ren_cnt;
            repeat (4) tick();
            check("idle_ren", ren_cnt, r);
            check("idle_valid", 32'(bus.m_valid), 0);
        end

        // en dropped while one read is in flight
        clear_stats();
        bus.m_ready = 1'b1;
        for (int k = 0; k < 8; k++) push_word(32'h60 + data_t'(k));
        tick();
        en = 1'b0;
        repeat (5) tick();
        check("en_off_ren", ren_cnt, 1);
        check("en_off_pop", pop_cnt, 1);
        en = 1'b1;
        drain();
        check("en_resume_ren", ren_cnt, 8);
        check("en_resume_pop", pop_cnt, 8);

        // Asynchronous reset with two words buffered
        clear_stats();
        bus.m_ready = 1'b0;
        for (int k = 0; k < 4; k++) push_word(32'h70 + data_t'(k));
        repeat (4) tick();
        check("pre_rst_busy", 32'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_m_valid", 32'(bus.m_valid), 0);
        check("async_busy", 32'(busy), 0);
        check("async_m_data", bus.m_data, 0);
        check("async_r_en", 32'(bus.r_en), 0);
`ifdef FIFO_RD_STREAM_STATS_EN
        check("rst_xfer_cnt", xfer_cnt, 0);
        check("rst_stall_cnt", stall_cnt, 0);
`endif
        fifo_q.delete();
        exp_q.delete();
        bus.empty = 1'b1;
        bus.r_data = '0;
        tick();
        rst_n = 1'b1;
        bus.m_ready = 1'b1;
        clear_stats();
        repeat (5) tick();
        check("post_rst_valid", valid_cyc, 0);
        check("post_rst_ren", ren_cnt, 0);
        push_word(32'h81);
        push_word(32'h82);
        drain();
        check("post_rst_pop", pop_cnt, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
